// File: rtl/digota_deadtime.sv
// Gate drive for the om/op/cm legs of the DiffDIGOTA output stage.
// Synchronises gate requests and enforces break-before-make with a dead time.
module digota_deadtime #(
    parameter int DEAD_CYC    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ompmos_req,
    input  logic       omnmos_req,
    input  logic       oppmos_req,
    input  logic       opnmos_req,
    input  logic       cmpmos_req,
    input  logic       cmnmos_req,
    input  logic       fault_clr,
    output logic       ompmos,
    output logic       omnmos,
    output logic       oppmos,
    output logic       opnmos,
    output logic       cmpmos,
    output logic       cmnmos,
    output logic [2:0] busy,
    output logic       fault
);

    localparam int CW = $clog2(DEAD_CYC + 1);

    // State bits are {dead, p, n} so the gate outputs come straight
    // from flops and can never glitch into a both-on combination.
    typedef enum logic [2:0] {
        S_HI   = 3'b000,
        S_OFF  = 3'b010,
        S_LO   = 3'b011,
        S_DEAD = 3'b110
    } state_t;

    typedef enum logic [1:0] {
        T_NONE = 2'd0,
        T_HI   = 2'd1,
        T_LO   = 2'd2
    } tgt_t;

    logic [2:0] preq_raw;
    logic [2:0] nreq_raw;
    logic [2:0] preq_s;
    logic [2:0] nreq_s;
    logic [2:0] pg;
    logic [2:0] ng;
    logic [2:0] conflict;

    assign preq_raw = {cmpmos_req, oppmos_req, ompmos_req};
    assign nreq_raw = {cmnmos_req, opnmos_req, omnmos_req};

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign preq_s = preq_raw;
            assign nreq_s = nreq_raw;
        end else begin : g_sync
            logic [2:0] psync [SYNC_STAGES];
            logic [2:0] nsync [SYNC_STAGES];

            // Request synchroniser chains; reset parks them at the off request.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        psync[i] <= '1;
                        nsync[i] <= '0;
                    end
                end else begin
                    psync[0] <= preq_raw;
                    nsync[0] <= nreq_raw;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        psync[i] <= psync[i-1];
                        nsync[i] <= nsync[i-1];
                    end
                end
            end

            assign preq_s = psync[SYNC_STAGES-1];
            assign nreq_s = nsync[SYNC_STAGES-1];
        end
    endgenerate

    // pmos-on together with nmos-on is the shoot-through request.
    assign conflict = ~preq_s & nreq_s;

    for (genvar g = 0; g < 3; g++) begin : g_leg
        state_t          st;
        state_t          st_nxt;
        logic [CW-1:0]   cnt;
        logic [CW-1:0]   cnt_nxt;
        tgt_t            tgt;

        // Decode the leg target; conflicts and en=0 both mean off.
        always_comb begin
            tgt = T_NONE;
            if (en && !preq_s[g] && !nreq_s[g]) begin
                tgt = T_HI;
            end else if (en && preq_s[g] && nreq_s[g]) begin
                tgt = T_LO;
            end
        end

        // Next state: any departure from a drive passes through a full DEAD.
        always_comb begin
            st_nxt  = st;
            cnt_nxt = cnt;
            unique case (st)
                S_OFF: begin
                    if (tgt == T_HI) begin
                        st_nxt = S_HI;
                    end else if (tgt == T_LO) begin
                        st_nxt = S_LO;
                    end
                end
                S_HI: begin
                    if (tgt != T_HI) begin
                        st_nxt  = S_DEAD;
                        cnt_nxt = CW'(DEAD_CYC - 1);
                    end
                end
                S_LO: begin
                    if (tgt != T_LO) begin
                        st_nxt  = S_DEAD;
                        cnt_nxt = CW'(DEAD_CYC - 1);
                    end
                end
                S_DEAD: begin
                    if (cnt == '0) begin
                        if (tgt == T_HI) begin
                            st_nxt = S_HI;
                        end else if (tgt == T_LO) begin
                            st_nxt = S_LO;
                        end else begin
                            st_nxt = S_OFF;
                        end
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                default: begin
                    st_nxt  = S_OFF;
                    cnt_nxt = '0;
                end
            endcase
        end

        // Leg state and dead counter registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                st  <= S_OFF;
                cnt <= '0;
            end else begin
                st  <= st_nxt;
                cnt <= cnt_nxt;
            end
        end

        assign pg[g]   = st[1];
        assign ng[g]   = st[0];
        assign busy[g] = st[2];
    end

    // Sticky fault; a new conflict outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (|conflict) begin
            fault <= 1'b1;
        end else if (fault_clr) begin
            fault <= 1'b0;
        end
    end

    assign ompmos = pg[0];
    assign omnmos = ng[0];
    assign oppmos = pg[1];
    assign opnmos = ng[1];
    assign cmpmos = pg[2];
    assign cmnmos = ng[2];

endmodule

// File: tb/tb_digota_deadtime.sv
// Bench for digota_deadtime: directed scenarios then random traffic,
// all compared each cycle against a cycle-level behavioural model.
module tb_digota_deadtime;

    localparam int DC = 3;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       fault_clr = 1'b0;
    logic [2:0] preq = 3'b111;
    logic [2:0] nreq = 3'b000;
    logic       ompmos, omnmos, oppmos, opnmos, cmpmos, cmnmos;
    logic [2:0] busy;
    logic       fault;

    int checks = 0;
    int errors = 0;

    // Reference model: delayed request history plus per-leg drive mode
    // (0 off, 1 hi, 2 lo) and remaining dead cycles.
    logic [2:0] hp [SS];
    logic [2:0] hn [SS];
    int         mode [3];
    int         dl [3];
    logic       mfault;

    always #5 clk = ~clk;

    digota_deadtime #(
        .DEAD_CYC    (DC),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ompmos_req (preq[0]),
        .omnmos_req (nreq[0]),
        .oppmos_req (preq[1]),
        .opnmos_req (nreq[1]),
        .cmpmos_req (preq[2]),
        .cmnmos_req (nreq[2]),
        .fault_clr  (fault_clr),
        .ompmos     (ompmos),
        .omnmos     (omnmos),
        .oppmos     (oppmos),
        .opnmos     (opnmos),
        .cmpmos     (cmpmos),
        .cmnmos     (cmnmos),
        .busy       (busy),
        .fault      (fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [2:0] sp;
        logic [2:0] sn;
        int         tgt;
        sp = hp[SS-1];
        sn = hn[SS-1];
        if (rst) begin
            for (int i = 0; i < SS; i++) begin
                hp[i] = 3'b111;
                hn[i] = 3'b000;
            end
            for (int l = 0; l < 3; l++) begin
                mode[l] = 0;
                dl[l]   = 0;
            end
            mfault = 1'b0;
            return;
        end
        for (int l = 0; l < 3; l++) begin
            if (!en) tgt = 0;
            else if (!sp[l] && !sn[l]) tgt = 1;
            else if (sp[l] && sn[l]) tgt = 2;
            else tgt = 0;
            if (dl[l] > 0) begin
                dl[l]--;
                if (dl[l] == 0) mode[l] = tgt;
            end else if (mode[l] == 0) begin
                mode[l] = tgt;
            end else if (tgt != mode[l]) begin
                dl[l] = DC;
            end
        end
        if ((~sp & sn) != 3'b000) mfault = 1'b1;
        else if (fault_clr) mfault = 1'b0;
        for (int i = SS - 1; i > 0; i--) begin
            hp[i] = hp[i-1];
            hn[i] = hn[i-1];
        end
        hp[0] = preq;
        hn[0] = nreq;
    endtask

    task automatic check_all();
        logic [2:0] ep, en_, eb, op, on;
        for (int l = 0; l < 3; l++) begin
            eb[l] = (dl[l] > 0);
            if (dl[l] > 0 || mode[l] == 0) begin
                ep[l] = 1'b1; en_[l] = 1'b0;
            end else if (mode[l] == 1) begin
                ep[l] = 1'b0; en_[l] = 1'b0;
            end else begin
                ep[l] = 1'b1; en_[l] = 1'b1;
            end
        end
        op = {cmpmos, oppmos, ompmos};
        on = {cmnmos, opnmos, omnmos};
        chk("model", {22'd0, op, on, busy, fault},
            {22'd0, ep, en_, eb, mfault});
        chk("no_shoot", {29'd0, ~op & on}, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int k;
        // 1: reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst_p", {29'd0, cmpmos, oppmos, ompmos}, 32'd7);
        chk("rst_n", {29'd0, cmnmos, opnmos, omnmos}, 32'd0);
        chk("rst_busy", {29'd0, busy}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        rst = 1'b0;
        en  = 1'b1;
        tick();

        // 2: om off -> hi after SS+1 edges
        preq[0] = 1'b0;
        tick();
        tick();
        chk("t2_early", {31'd0, ompmos}, 32'd1);
        tick();
        chk("t2_hi", {31'd0, ompmos}, 32'd0);
        chk("t2_busy", {31'd0, busy[0]}, 32'd0);

        // 3: om hi -> lo through dead
        preq[0] = 1'b1;
        nreq[0] = 1'b1;
        tick();
        tick();
        tick();
        chk("t3_rel", {30'd0, ompmos, busy[0]}, 32'd3);
        chk("t3_n_off", {31'd0, omnmos}, 32'd0);
        tick();
        tick();
        chk("t3_n_wait", {31'd0, omnmos}, 32'd0);
        tick();
        chk("t3_lo", {30'd0, omnmos, busy[0]}, 32'd2);

        // 5: op lo, en dropped then restored mid dead
        preq[1] = 1'b1;
        nreq[1] = 1'b1;
        repeat (4) tick();
        chk("t5_lo", {31'd0, opnmos}, 32'd1);
        en = 1'b0;
        tick();
        chk("t5_n_off", {30'd0, opnmos, busy[1]}, 32'd1);
        tick();
        en = 1'b1;
        tick();
        chk("t5_still_dead", {31'd0, busy[1]}, 32'd1);
        tick();
        chk("t5_dead_end", {31'd0, busy[1]}, 32'd0);

        // 4: cm conflict, clear blocked while present, then cleared
        preq[2] = 1'b0;
        nreq[2] = 1'b1;
        fault_clr = 1'b1;
        tick();
        tick();
        chk("t4_pre", {31'd0, fault}, 32'd0);
        tick();
        chk("t4_fault", {31'd0, fault}, 32'd1);
        chk("t4_cm_off", {30'd0, cmpmos, cmnmos}, 32'd2);
        preq[2] = 1'b1;
        nreq[2] = 1'b0;
        tick();
        tick();
        chk("t4_set_wins", {31'd0, fault}, 32'd1);
        tick();
        chk("t4_cleared", {31'd0, fault}, 32'd0);
        fault_clr = 1'b0;
        tick();

        // 6: reset during om dead
        repeat (4) tick();
        preq[0] = 1'b0;
        nreq[0] = 1'b0;
        repeat (3) tick();
        chk("t6_dead", {31'd0, busy[0]}, 32'd1);
        rst = 1'b1;
        tick();
        chk("t6_off", {30'd0, ompmos, omnmos}, 32'd2);
        chk("t6_busy", {29'd0, busy}, 32'd0);
        rst = 1'b0;

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            for (int l = 0; l < 3; l++) begin
                if ($urandom_range(0, 5) == 0) begin
                    k = $urandom_range(0, 9);
                    if (k < 4) begin
                        preq[l] = 1'b0; nreq[l] = 1'b0;
                    end else if (k < 8) begin
                        preq[l] = 1'b1; nreq[l] = 1'b1;
                    end else if (k == 8) begin
                        preq[l] = 1'b1; nreq[l] = 1'b0;
                    end else begin
                        preq[l] = 1'b0; nreq[l] = 1'b1;
                    end
                end
            end
            en        = ($urandom_range(0, 15) != 0);
            fault_clr = ($urandom_range(0, 7) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
